fpmult_norm_round: RTL and testbench

FPMULT_NORM_ROUND -- requirements
Module: fpmult_norm_round

---
 rtl/fpmult_norm_round.sv | 172 +++++++++++++++++
 tb/tb_fpmult_norm_round.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fpmult_norm_round.sv
// -----------------------------------------------------------------------------
// fpmult_norm_round
//   Final two pipeline stages of a single-precision floating-point multiplier:
//   normalise the 48-bit mantissa product, round it (nearest-even or
//   truncate), and pack the IEEE-754 result with overflow/underflow flags.
//   Valid/ready handshake on both sides; one result per cycle, latency 2.
//
// Parameters
//   ROUND_EN  1 = round-to-nearest-even, 0 = truncate
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   upstream product fields valid
//   in_ready   block accepts the input this cycle
//   Mp[47:0]   unsigned 24x24 mantissa product
//   Ep[9:0]    two's-complement exponent sum Ea+Eb-127 (sign-extended)
//   Sp         product sign
//   Zp         either operand was zero
//   out_valid  P/Ovf/Unf valid
//   out_ready  downstream accepts the result
//   P[31:0]    IEEE-754 single-precision result
//   Ovf        result overflowed to infinity
//   Unf        result underflowed and was flushed to zero
// -----------------------------------------------------------------------------
module fpmult_norm_round #(
  parameter int ROUND_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] Mp,
  input  logic [9:0]  Ep,
  input  logic        Sp,
  input  logic        Zp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] P,
  output logic        Ovf,
  output logic        Unf
);

  // ---------------------------------------------------------------------------
  // Handshake / stage-advance control
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic s2_valid;
  logic s1_load;
  logic s2_load;

  // A stage may load when it is empty or when its contents move on this cycle;
  // in_ready is therefore combinational from out_ready through both stages.
  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  // ---------------------------------------------------------------------------
  // Stage 1: capture the product fields
  // ---------------------------------------------------------------------------
  logic [47:0] s1_mp;
  logic [9:0]  s1_ep;
  logic        s1_sp;
  logic        s1_zp;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      s1_valid <= in_valid;
    end
  end

  // NOTE: datapath registers carry no reset; their contents are only ever
  // consumed when the matching valid bit is set, and valid bits are reset.
  always_ff @(posedge clk) begin
    if (!rst && s1_load && in_valid) begin
      s1_mp <= Mp;
      s1_ep <= Ep;
      s1_sp <= Sp;
      s1_zp <= Zp;
    end
  end

  // ---------------------------------------------------------------------------
  // Normalise, round and pack (combinational, S1 -> S2)
  // ---------------------------------------------------------------------------
  logic [22:0]        m_norm;
  logic               guard_bit;
  logic               sticky_bit;
  logic signed [10:0] ep_ext;
  logic signed [10:0] e_norm;
  logic               round_up;
  logic [23:0]        m_sum;
  logic signed [10:0] e_round;
  logic [31:0]        p_next;
  logic               ovf_next;
  logic               unf_next;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave a value unassigned and infer a latch.
    m_norm     = '0;
    guard_bit  = 1'b0;
    sticky_bit = 1'b0;
    p_next     = '0;
    ovf_next   = 1'b0;
    unf_next   = 1'b0;

    // 11-bit signed exponent: the +1 from normalisation and the +1 from a
    // rounding carry can never wrap.
    ep_ext = {s1_ep[9], s1_ep};

    if (s1_mp[47]) begin
      // Product in [2,4): shift right by one and bump the exponent.
      m_norm     = s1_mp[46:24];
      guard_bit  = s1_mp[23];
      sticky_bit = |s1_mp[22:0];
      e_norm     = ep_ext + 11'sd1;
    end else begin
      m_norm     = s1_mp[45:23];
      guard_bit  = s1_mp[22];
      sticky_bit = |s1_mp[21:0];
      e_norm     = ep_ext;
    end

    // Nearest-even: round up above half, or at exactly half when m is odd.
    round_up = (ROUND_EN != 0) && guard_bit && (sticky_bit || m_norm[0]);

    // Carry out of the 23-bit fraction leaves the fraction at zero (wrap of
    // the sum) and moves the value up one binade.
    m_sum   = {1'b0, m_norm} + 24'(round_up);
    e_round = e_norm + 11'(m_sum[23]);

    if (s1_zp) begin
      p_next = {s1_sp, 31'b0};
    end else if (e_round >= 11'sd255) begin
      p_next   = {s1_sp, 8'hFF, 23'b0};
      ovf_next = 1'b1;
    end else if (e_round <= 11'sd0) begin
      p_next   = {s1_sp, 31'b0};
      unf_next = 1'b1;
    end else begin
      p_next = {s1_sp, e_round[7:0], m_sum[22:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: result register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      P        <= '0;
      Ovf      <= 1'b0;
      Unf      <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      // Result fields only change on a real transfer, so they are held
      // stable for the whole of any downstream stall.
      if (s1_valid) begin
        P   <= p_next;
        Ovf <= ovf_next;
        Unf <= unf_next;
      end
    end
  end

endmodule

// File: tb/tb_fpmult_norm_round.sv
// -----------------------------------------------------------------------------
// tb_fpmult_norm_round
//   Directed bench for fpmult_norm_round. Two instances share all inputs: one
//   rounds to nearest-even, the other truncates. Expected results are pushed
//   to per-instance queues when an input is accepted and popped by a monitor
//   when the instance presents a result.
// -----------------------------------------------------------------------------
module tb_fpmult_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [47:0] mp;
  logic [9:0]  ep;
  logic        sp;
  logic        zp;

  logic        in_ready0, out_valid0, ovf0, unf0;
  logic [31:0] p0;
  logic        in_ready1, out_valid1, ovf1, unf1;
  logic [31:0] p1;

  typedef struct packed {
    logic [31:0] p;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int          checks = 0;
  int          errors = 0;
  int          n_acc  = 0;
  bit          held   = 1'b0;
  logic [31:0] held_p;

  always #5 clk = ~clk;

  fpmult_norm_round #(.ROUND_EN(1)) dut_rn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .Mp(mp), .Ep(ep), .Sp(sp), .Zp(zp),
    .out_valid(out_valid0), .out_ready(out_ready),
    .P(p0), .Ovf(ovf0), .Unf(unf0)
  );

  fpmult_norm_round #(.ROUND_EN(0)) dut_tr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .Mp(mp), .Ep(ep), .Sp(sp), .Zp(zp),
    .out_valid(out_valid1), .out_ready(out_ready),
    .P(p1), .Ovf(ovf1), .Unf(unf1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one input and hold it until accepted (bounded). Expected results
  // for both instances are queued at the moment of acceptance.
  task automatic send(input logic [47:0] m, input logic [9:0] e, input logic s,
                      input logic z, input logic [31:0] p_rn, input logic [31:0] p_tr,
                      input logic ovf, input logic unf);
    bit done = 1'b0;
    in_valid = 1'b1;
    mp = m;
    ep = e;
    sp = s;
    zp = z;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in_ready0 && in_ready1 && !rst) begin
        q0.push_back({p_rn, ovf, unf});
        q1.push_back({p_tr, ovf, unf});
        n_acc++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("accept", 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (q0.size() + q1.size()) != 0; i++) begin
      @(posedge clk);
    end
    #1;
    check("drain", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  // Scoreboard monitor and stall-stability checker.
  always @(negedge clk) begin
    exp_t x;
    if (!rst && out_valid0 && out_ready) begin
      check("rn_expected_pending", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        x = q0.pop_front();
        check("rn_P", p0, x.p);
        check("rn_flags", {30'b0, ovf0, unf0}, {30'b0, x.ovf, x.unf});
      end
    end
    if (!rst && out_valid1 && out_ready) begin
      check("tr_expected_pending", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        x = q1.pop_front();
        check("tr_P", p1, x.p);
        check("tr_flags", {30'b0, ovf1, unf1}, {30'b0, x.ovf, x.unf});
      end
    end
    if (!rst && out_valid0 && !out_ready) begin
      if (held) check("hold_P", p0, held_p);
      held_p = p0;
      held   = 1'b1;
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    int base;

    // Reset with a valid input presented: it must not be accepted.
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    mp        = 48'h400000000000;
    ep        = 10'd127;
    sp        = 1'b0;
    zp        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_P", p0, 32'h0);
    check("rst_flags", {30'b0, ovf0, unf0}, 32'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    check("in_ready_after_rst", 32'(in_ready0), 32'd1);

    // Basic products.
    send(48'h400000000000, 10'd127, 1'b0, 1'b0, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
    send(48'h900000000000, 10'd127, 1'b0, 1'b0, 32'h40100000, 32'h40100000, 1'b0, 1'b0);
    send(48'h900000000000, 10'd127, 1'b1, 1'b0, 32'hC0100000, 32'hC0100000, 1'b0, 1'b0);

    // Rounding. 7FFFFF800000 has m all ones but G=Mp[22]=0, so it never
    // rounds; 7FFFFFC00000 sets G so nearest-even carries into the exponent.
    send(48'h7FFFFF800000, 10'd127, 1'b0, 1'b0, 32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0, 1'b0);
    send(48'h7FFFFFC00000, 10'd127, 1'b0, 1'b0, 32'h40000000, 32'h3FFFFFFF, 1'b0, 1'b0);
    // Tie with even m: stays.
    send(48'h400000400000, 10'd127, 1'b0, 1'b0, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
    // Tie with odd m: rounds up to even.
    send(48'h400000C00000, 10'd127, 1'b0, 1'b0, 32'h3F800002, 32'h3F800001, 1'b0, 1'b0);
    // Above half (sticky set): rounds up.
    send(48'h400000600000, 10'd127, 1'b0, 1'b0, 32'h3F800001, 32'h3F800000, 1'b0, 1'b0);

    // Exponent boundaries.
    send(48'h800000000000, 10'd254, 1'b0, 1'b0, 32'h7F800000, 32'h7F800000, 1'b1, 1'b0);
    send(48'h400000000000, 10'd254, 1'b0, 1'b0, 32'h7F000000, 32'h7F000000, 1'b0, 1'b0);
    send(48'h400000000000, 10'd1,   1'b0, 1'b0, 32'h00800000, 32'h00800000, 1'b0, 1'b0);
    send(48'h400000000000, 10'd0,   1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
    send(48'h400000000000, 10'h3FB, 1'b1, 1'b0, 32'h80000000, 32'h80000000, 1'b0, 1'b1);
    // Zero operand beats everything, sign preserved.
    send(48'h000000000000, 10'd127, 1'b1, 1'b1, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
    drain();

    // Backpressure: five back-to-back inputs, output stalled for four cycles.
    base      = n_acc;
    out_ready = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        #1;
        check("bp_in_ready", 32'(in_ready0), 32'd0);
        check("bp_accepts", 32'(n_acc - base), 32'd2);
        check("bp_out_valid", 32'(out_valid0), 32'd1);
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 5; i++) begin
          send(48'h400000000000, 10'(120 + i), 1'b0, 1'b0,
               {1'b0, 8'(120 + i), 23'b0}, {1'b0, 8'(120 + i), 23'b0}, 1'b0, 1'b0);
        end
      end
    join
    drain();

    // Reset with both stages full: in-flight results are discarded.
    out_ready = 1'b0;
    send(48'h900000000000, 10'd130, 1'b0, 1'b0, 32'h41900000, 32'h41900000, 1'b0, 1'b0);
    send(48'h400000000000, 10'd130, 1'b1, 1'b0, 32'hC1000000, 32'hC1000000, 1'b0, 1'b0);
    check("full_in_ready", 32'(in_ready0), 32'd0);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    check("midrst_out_valid_rn", 32'(out_valid0), 32'd0);
    check("midrst_out_valid_tr", 32'(out_valid1), 32'd0);
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready0), 32'd1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(48'h400000000000, 10'd128, 1'b0, 1'b0, 32'h40000000, 32'h40000000, 1'b0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
